// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 Hz VGA timing generator.
// Produces a pixel-rate tick from the system clock, free-running x/y
// counters that cover both the visible area and the blanking intervals,
// active-low sync pulses, a visible-area flag and a frame-start pulse.
// Every output is a flop or a pure decode of flops.
// CLK_DIV must lie in 1..16 (the divider register is 4 bits wide).
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_tick,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Constants are held in 11 bits so that the porch/sync sums never wrap.
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_FIRST   = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_LAST    = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST   = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_LAST    = 11'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [3:0]  DIV_LAST   = 4'(CLK_DIV - 1);

    logic [3:0] div_reg;
    logic [3:0] div_next;
    logic [9:0] x_reg;
    logic [9:0] x_next;
    logic [9:0] y_reg;
    logic [9:0] y_next;
    logic       hsync_reg;
    logic       hsync_next;
    logic       vsync_reg;
    logic       vsync_next;
    logic       frame_start_reg;
    logic       frame_start_next;
    logic       tick;
    logic       x_at_last;
    logic       y_at_last;

    // Last clk of a pixel slot; with CLK_DIV=1 div_reg stays 0 and this is always high.
    assign tick      = (div_reg == DIV_LAST);
    assign x_at_last = ({1'b0, x_reg} == H_LAST);
    assign y_at_last = ({1'b0, y_reg} == V_LAST);

    // Next-state counters and the sync/frame decodes taken from them.
    always_comb begin
        div_next         = div_reg;
        x_next           = x_reg;
        y_next           = y_reg;
        frame_start_next = 1'b0;
        if (tick) begin
            div_next = 4'd0;
            if (x_at_last) begin
                x_next = 10'd0;
                if (y_at_last) begin
                    y_next           = 10'd0;
                    frame_start_next = 1'b1;
                end else begin
                    y_next = y_reg + 10'd1;
                end
            end else begin
                x_next = x_reg + 10'd1;
            end
        end else begin
            div_next = div_reg + 4'd1;
        end
        // Syncs are decoded from the next counter values so they switch on
        // the same edge as x_pos/y_pos.
        hsync_next = !(({1'b0, x_next} >= HS_FIRST) && ({1'b0, x_next} <= HS_LAST));
        vsync_next = !(({1'b0, y_next} >= VS_FIRST) && ({1'b0, y_next} <= VS_LAST));
    end

    // State registers; reset overrides any counting in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg         <= 4'd0;
            x_reg           <= 10'd0;
            y_reg           <= 10'd0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            frame_start_reg <= 1'b0;
        end else begin
            div_reg         <= div_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign pix_tick    = tick;
    assign x_pos       = x_reg;
    assign y_pos       = y_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign video_on    = ({1'b0, x_reg} < H_VIS_END) && ({1'b0, y_reg} < V_VIS_END);
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen: two instances (CLK_DIV=2 and CLK_DIV=1) with
// shortened vertical timing so whole frames fit in a short run. Outputs are
// compared every cycle against an arithmetic model derived from elapsed
// clocks since reset release, plus directed checks on pulse widths/spacing.
module tb_vga_sync_gen;

    localparam int HT       = 800;
    localparam int A_DIV    = 2;
    localparam int A_VT     = 10;   // 4 visible + 2 fp + 2 sync + 2 bp
    localparam int A_VS_LO  = 6;
    localparam int A_VS_HI  = 7;
    localparam int A_VVIS   = 4;
    localparam int B_DIV    = 1;
    localparam int B_VT     = 8;    // 4 visible + 1 fp + 2 sync + 1 bp
    localparam int B_VS_LO  = 5;
    localparam int B_VS_HI  = 6;
    localparam int B_VVIS   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_tick, a_hs, a_vs, a_von, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_tick, b_hs, b_vs, b_von, b_fs;
    logic [9:0] b_x, b_y;

    int n_cmp = 0;
    int n_err = 0;
    longint t = 0;   // clk edges since reset release

    always #5 clk = ~clk;

    vga_sync_gen #(.V_VISIBLE(4), .V_FP(2), .V_SYNC(2), .V_BP(2), .CLK_DIV(A_DIV)) dut_a (
        .clk(clk), .rst(rst), .pix_tick(a_tick), .x_pos(a_x), .y_pos(a_y),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .frame_start(a_fs)
    );

    vga_sync_gen #(.V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(B_DIV)) dut_b (
        .clk(clk), .rst(rst), .pix_tick(b_tick), .x_pos(b_x), .y_pos(b_y),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .frame_start(b_fs)
    );

    // Elapsed-time reference: zero while in reset, +1 per running edge.
    always @(posedge clk) begin
        if (rst) t <= 0;
        else     t <= t + 1;
    end

    // Expected {pix_tick, x, y, hsync, vsync, video_on, frame_start} after t clks.
    function automatic logic [24:0] model(longint tt, int cdiv, int vt, int vs_lo, int vs_hi, int vvis);
        longint p, x, y;
        logic pt, hs, vs, von, fs;
        p   = tt / cdiv;
        x   = p % HT;
        y   = (p / HT) % vt;
        pt  = ((tt % cdiv) == cdiv - 1);
        hs  = !(x >= 656 && x <= 751);
        vs  = !(y >= vs_lo && y <= vs_hi);
        von = (x < 640) && (y < vvis);
        fs  = (tt > 0) && ((tt % (cdiv * HT * vt)) == 0);
        return {pt, 10'(x), 10'(y), hs, vs, von, fs};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic check_dut(input string d, input logic [24:0] obs, input logic [24:0] exp);
        chk({d, ".pix_tick"},    32'(obs[24]),    32'(exp[24]));
        chk({d, ".x_pos"},       32'(obs[23:14]), 32'(exp[23:14]));
        chk({d, ".y_pos"},       32'(obs[13:4]),  32'(exp[13:4]));
        chk({d, ".hsync"},       32'(obs[3]),     32'(exp[3]));
        chk({d, ".vsync"},       32'(obs[2]),     32'(exp[2]));
        chk({d, ".video_on"},    32'(obs[1]),     32'(exp[1]));
        chk({d, ".frame_start"}, 32'(obs[0]),     32'(exp[0]));
    endtask

    // Advance one clk and compare both instances against the model.
    task automatic step();
        @(negedge clk);
        check_dut("A", {a_tick, a_x, a_y, a_hs, a_vs, a_von, a_fs},
                  model(t, A_DIV, A_VT, A_VS_LO, A_VS_HI, A_VVIS));
        check_dut("B", {b_tick, b_x, b_y, b_hs, b_vs, b_von, b_fs},
                  model(t, B_DIV, B_VT, B_VS_LO, B_VS_HI, B_VVIS));
    endtask

    initial begin
        int a_ticks, a_hs_low, b_ticks, b_hs_low, a_fs_cnt, b_fs_cnt;
        int a_hs_fall_x, b_hs_fall_x;
        longint a_fs_first, a_fs_gap, a_fs_prev, b_fs_first;
        logic a_hs_prev, b_hs_prev, found;

        // Reset held for 3 edges, outputs sampled after the last one.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.A.x", 32'(a_x), 32'd0);
        chk("reset.A.y", 32'(a_y), 32'd0);
        chk("reset.A.hsync", 32'(a_hs), 32'd1);
        chk("reset.A.vsync", 32'(a_vs), 32'd1);
        chk("reset.A.video_on", 32'(a_von), 32'd1);
        chk("reset.A.frame_start", 32'(a_fs), 32'd0);
        chk("reset.A.pix_tick", 32'(a_tick), 32'd0);
        chk("reset.B.pix_tick", 32'(b_tick), 32'd1);
        rst = 1'b0;

        // Two full frames of instance A (and several of B), checked every clk.
        a_ticks = 0; a_hs_low = 0; b_ticks = 0; b_hs_low = 0;
        a_fs_cnt = 0; b_fs_cnt = 0; a_fs_first = -1; a_fs_gap = -1; a_fs_prev = -1;
        b_fs_first = -1; a_hs_fall_x = -1; b_hs_fall_x = -1;
        a_hs_prev = 1'b1; b_hs_prev = 1'b1;
        for (int i = 1; i <= 2 * A_DIV * HT * A_VT + 100; i++) begin
            step();
            if (i <= A_DIV * HT) begin
                if (a_tick) a_ticks++;
                if (!a_hs)  a_hs_low++;
            end
            if (i <= B_DIV * HT) begin
                if (b_tick) b_ticks++;
                if (!b_hs)  b_hs_low++;
            end
            if (a_hs_prev && !a_hs && a_hs_fall_x < 0) a_hs_fall_x = int'(a_x);
            if (b_hs_prev && !b_hs && b_hs_fall_x < 0) b_hs_fall_x = int'(b_x);
            a_hs_prev = a_hs;
            b_hs_prev = b_hs;
            if (a_fs) begin
                a_fs_cnt++;
                if (a_fs_first < 0) a_fs_first = t;
                else if (a_fs_gap < 0) a_fs_gap = t - a_fs_prev;
                a_fs_prev = t;
            end
            if (b_fs) begin
                b_fs_cnt++;
                if (b_fs_first < 0) b_fs_first = t;
            end
        end
        chk("A.tick_count_line", 32'(a_ticks), 32'd800);
        chk("A.hsync_low_clks", 32'(a_hs_low), 32'd192);
        chk("A.hsync_fall_x", 32'(a_hs_fall_x), 32'd656);
        chk("B.tick_count_line", 32'(b_ticks), 32'd800);
        chk("B.hsync_low_clks", 32'(b_hs_low), 32'd96);
        chk("B.hsync_fall_x", 32'(b_hs_fall_x), 32'd656);
        chk("A.frame_start_count", 32'(a_fs_cnt), 32'd2);
        chk("A.frame_start_first", 32'(a_fs_first), 32'(A_DIV * HT * A_VT));
        chk("A.frame_start_gap", 32'(a_fs_gap), 32'(A_DIV * HT * A_VT));
        chk("B.frame_start_first", 32'(b_fs_first), 32'(B_DIV * HT * B_VT));

        // Mid-frame reset while A is inside both sync pulses.
        found = 1'b0;
        for (int i = 0; i < 2 * A_DIV * HT * A_VT && !found; i++) begin
            step();
            if (a_x == 10'd700 && a_y == 10'(A_VS_HI)) found = 1'b1;
        end
        chk("A.reached_700_7", 32'(found), 32'd1);
        chk("A.pre_reset_hsync", 32'(a_hs), 32'd0);
        chk("A.pre_reset_vsync", 32'(a_vs), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst.A.x", 32'(a_x), 32'd0);
        chk("midrst.A.y", 32'(a_y), 32'd0);
        chk("midrst.A.hsync", 32'(a_hs), 32'd1);
        chk("midrst.A.vsync", 32'(a_vs), 32'd1);
        chk("midrst.A.frame_start", 32'(a_fs), 32'd0);
        for (int i = 0; i < 2 * A_DIV * HT; i++) step();

        // Random run lengths interleaved with random-length resets.
        for (int k = 0; k < 10; k++) begin
            int n, m;
            n = int'($urandom_range(200, 1500));
            m = int'($urandom_range(1, 3));
            for (int i = 0; i < n; i++) step();
            rst = 1'b1;
            for (int i = 0; i < m; i++) step();
            rst = 1'b0;
        end
        for (int i = 0; i < 2000; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480@60 Hz VGA timing. It outputs active-low horizontal and vertical sync, a visible-area flag, and the current pixel coordinates `x_pos`/`y_pos`. It is the coordinate source for the grid-mapping and pixel-colour logic downstream, and sits between the board clock and the VGA connector. Downstream blocks must qualify `x_pos`/`y_pos` with `video_on`, because the counters also run through the blanking intervals (x up to 799, y up to 524).

## Interface

Parameters:
- `H_VISIBLE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: horizontal sync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_VISIBLE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `CLK_DIV`, 2: clk cycles per pixel (50 MHz clk gives a 25 MHz pixel rate); legal range 1..16

Ports:
- `clk` in 1: system clock; only clock in the block
- `rst` in 1: synchronous, active-high reset
- `pix_tick` out 1: one-clk pulse marking the last clk cycle of each pixel slot
- `x_pos` out 10: horizontal counter, range 0..H_TOTAL-1
- `y_pos` out 10: vertical counter, range 0..V_TOTAL-1
- `hsync` out 1: horizontal sync, active low
- `vsync` out 1: vertical sync, active low
- `video_on` out 1: high when x_pos < H_VISIBLE and y_pos < V_VISIBLE
- `frame_start` out 1: one-clk pulse on the first clk of each new frame

## Operation

- Derived constants: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Output sourcing: every output is either a flop or a pure decode of flops. No output has a combinational path from an input.
- Divider: `div_cnt` counts 0..CLK_DIV-1 and wraps. `pix_tick` = (div_cnt == CLK_DIV-1). With CLK_DIV=1, `pix_tick` is constantly 1 once out of reset.
- Horizontal counter: x_pos advances only on `pix_tick`. At H_TOTAL-1 it wraps to 0.
- Vertical counter: y_pos advances only on a `pix_tick` where x_pos == H_TOTAL-1. At V_TOTAL-1 it wraps to 0.
- hsync: low exactly while x_pos is in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] = [656, 751].
- vsync: low exactly while y_pos is in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] = [490, 491].
- Sync alignment: hsync and vsync are registered from the next-state counter values, so they change on the same clk edge as x_pos/y_pos and are never skewed against them.
- video_on: decoded from the x_pos/y_pos registers.
- frame_start: registered. High for one clk in the cycle where x_pos/y_pos first read (0,0) after wrapping from (H_TOTAL-1, V_TOTAL-1). It is not asserted on leaving reset.
- Reset values (`rst` high at a clk edge):
  - div_cnt=0, x_pos=0, y_pos=0
  - hsync=1, vsync=1
  - video_on=1 (decode of the reset counter values)
  - pix_tick=0 when CLK_DIV>1; frame_start=0
- Reset has priority over all counting. Asserting reset mid-frame returns every output to its reset value on the next edge, regardless of counter state.
- Arithmetic: counters are 10 bits. Comparisons against the derived constants use at least 11 bits, so constant sums cannot overflow.

## Timing

- Pixel slot: each (x_pos, y_pos) value is held for exactly CLK_DIV clk cycles. `pix_tick` is high in the last of those cycles.
- Line: H_TOTAL*CLK_DIV clk cycles (1600 at the defaults).
- Frame: V_TOTAL lines, i.e. 840000 clks at the defaults.
- hsync low pulse: H_SYNC*CLK_DIV clks (192). It falls on the edge where x_pos becomes 656.
- vsync low pulse: V_SYNC lines (3200 clks). It falls on the edge where y_pos becomes 490 with x_pos becoming 0.
- First pixel after reset: counting starts on the first edge with `rst` low. The first x_pos increment (0 to 1) happens CLK_DIV clks later.
- Startup frame_start: the first pulse occurs one full frame after reset release.

## Test plan

- Reset: hold rst for 3 clks, sampling outputs on the clk after the last reset edge -> x_pos=0, y_pos=0, hsync=1, vsync=1, video_on=1, frame_start=0, pix_tick=0.
- Pixel rate, CLK_DIV=2: run 1600 clks -> pix_tick high every 2nd clk (800 pulses); x_pos runs 0..799 and wraps to 0; y_pos increments from 0 to 1 at the wrap.
- hsync: on line 0 -> hsync goes low on the edge where x_pos=656 and stays low for 192 clks; it is high again when x_pos=752; video_on=0 for x_pos in 640..799.
- vsync and frame wrap: run a full frame -> vsync low for y_pos 490..491 only; on the edge where (799,524) wraps to (0,0), frame_start is high for exactly 1 clk; spacing between consecutive frame_start pulses is 840000 clks.
- Mid-frame reset: assert rst for 1 clk at x_pos=700, y_pos=491 (hsync and vsync both low) -> next edge gives x=0, y=0, hsync=1, vsync=1, with no frame_start pulse.
- CLK_DIV=1 build: pix_tick constantly 1 after reset; line = 800 clks; hsync low for 96 clks starting at x_pos=656.
